// File: rtl/gpio_in_pkg.sv
// Register offsets, CTRL field positions and prime sequencer states
// shared by the GPIO input demux and its per-bit filter.
package gpio_in_pkg;

    localparam logic [2:0] REG_FILT0   = 3'd0;
    localparam logic [2:0] REG_FILT1   = 3'd1;
    localparam logic [2:0] REG_FILT2   = 3'd2;
    localparam logic [2:0] REG_STICKY0 = 3'd3;
    localparam logic [2:0] REG_STICKY1 = 3'd4;
    localparam logic [2:0] REG_STICKY2 = 3'd5;
    localparam logic [2:0] REG_CTRL    = 3'd6;

    localparam int CTRL_LEN_LSB = 0;
    localparam int CTRL_IRQ_EN  = 4;

    localparam logic [1:0] PRIME_LAST = 2'd2;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } prime_state_t;

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input bit: two-flop synchronizer, length-L debounce counter
// and a sticky change flag (a set beats a coincident clear).
module gpio_in_filter #(
    parameter int FiltBits = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pin,
    input  logic                prime,
    input  logic [FiltBits-1:0] len,
    input  logic                clr,
    output logic                filt,
    output logic                sticky
);

    logic                meta;
    logic                sync;
    logic [FiltBits-1:0] cnt;
    logic                hit;

    // The raw pin is asynchronous; data-only flops, no reset needed
    always_ff @(posedge clk) begin
        meta <= pin;
        sync <= meta;
    end

    assign hit = !prime && (sync != filt) && (cnt == len);

    // Debounce: accept the synced level after it disagrees for L+1 cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (prime) begin
            filt <= sync;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt == len) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt <= cnt + FiltBits'(1);
        end
    end

    // Sticky flag: filter acceptance sets, bus write-1 clears
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (hit) begin
            sticky <= 1'b1;
        end else if (clr) begin
            sticky <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_in_demux.sv
// Input side of the HostMot2 GPIO mux: debounces both headers into the
// IOBits vector and exposes filtered state, sticky change flags and
// filter control on the register bus.
module gpio_in_demux
    import gpio_in_pkg::*;
#(
    parameter int GPIOWidth = 36,
    parameter int NumGPIO   = 2,
    parameter int IOWidth   = 72,
    parameter int BusWidth  = 32,
    parameter int AddrWidth = 16,
    parameter int FiltBits  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [GPIOWidth*NumGPIO-1:0]   gpio_in,
    output logic [IOWidth-1:0]             io_bits_in,
    input  logic [AddrWidth-1:0]           addr,
    input  logic                           read_strobe,
    input  logic                           write_strobe,
    input  logic [BusWidth-1:0]            data_in,
    output logic [BusWidth-1:0]            data_out,
    output logic                           read_valid,
    output logic                           change_irq
);

    // Three bus words cover the IO vector; upper padding reads as zero
    localparam int PadW = 3 * BusWidth;

    logic [IOWidth-1:0]     filt;
    logic [IOWidth-1:0]     sticky;
    logic [IOWidth-1:0]     clr;
    logic [PadW-1:0]        filt_pad;
    logic [PadW-1:0]        sticky_pad;
    logic [PadW-1:0]        clr_pad;
    logic [PadW-1:BusWidth] shadow;
    logic [BusWidth-1:0]    rd_word;
    logic [FiltBits-1:0]    len;
    logic                   irq_en;
    prime_state_t           state;
    logic [1:0]             prime_cnt;
    logic                   prime;
    logic                   wr_en;
    logic [2:0]             reg_sel;
    logic                   unused_bits;

    assign prime      = (state == PRIME);
    assign wr_en      = write_strobe && !prime;
    assign reg_sel    = addr[2:0];
    assign filt_pad   = PadW'(filt);
    assign sticky_pad = PadW'(sticky);
    assign clr        = clr_pad[IOWidth-1:0];
    assign io_bits_in = filt;
    assign unused_bits = ^{addr[AddrWidth-1:3], clr_pad[PadW-1:IOWidth]};

    genvar h, i;
    generate
        for (h = 0; h < NumGPIO; h++) begin : g_hdr
            for (i = 0; i < GPIOWidth; i++) begin : g_pin
                gpio_in_filter #(
                    .FiltBits (FiltBits)
                ) u_filter (
                    .clk    (clk),
                    .reset  (reset),
                    .pin    (gpio_in[h*GPIOWidth+i]),
                    .prime  (prime),
                    .len    (len),
                    .clr    (clr[h*GPIOWidth+i]),
                    .filt   (filt[h*GPIOWidth+i]),
                    .sticky (sticky[h*GPIOWidth+i])
                );
            end
        end
    endgenerate

    // Write-1-to-clear mask for the sticky words (writes dropped in PRIME)
    always_comb begin
        clr_pad = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_STICKY0: clr_pad[BusWidth-1:0]          = data_in;
                REG_STICKY1: clr_pad[2*BusWidth-1:BusWidth] = data_in;
                REG_STICKY2: clr_pad[PadW-1:2*BusWidth]     = data_in;
                default:     ;
            endcase
        end
    end

    // Read mux; upper filt words come from the snapshot taken by a word-0 read
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_FILT0:   rd_word = filt_pad[BusWidth-1:0];
            REG_FILT1:   rd_word = shadow[2*BusWidth-1:BusWidth];
            REG_FILT2:   rd_word = shadow[PadW-1:2*BusWidth];
            REG_STICKY0: rd_word = sticky_pad[BusWidth-1:0];
            REG_STICKY1: rd_word = sticky_pad[2*BusWidth-1:BusWidth];
            REG_STICKY2: rd_word = sticky_pad[PadW-1:2*BusWidth];
            REG_CTRL: begin
                rd_word[CTRL_LEN_LSB +: FiltBits] = len;
                rd_word[CTRL_IRQ_EN]              = irq_en;
            end
            default:     ;
        endcase
    end

    // Prime sequencer: filters track the pins for three cycles after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PRIME;
            prime_cnt <= 2'd0;
        end else if (state == PRIME) begin
            if (prime_cnt == PRIME_LAST) begin
                state <= RUN;
            end else begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    // Read port: registered data, one-cycle valid, snapshot on word-0 read
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            read_valid <= 1'b0;
            shadow     <= '0;
        end else begin
            read_valid <= read_strobe;
            if (read_strobe) begin
                data_out <= rd_word;
                if (reg_sel == REG_FILT0) begin
                    shadow <= filt_pad[PadW-1:BusWidth];
                end
            end
        end
    end

    // Control register write
    always_ff @(posedge clk) begin
        if (reset) begin
            len    <= '0;
            irq_en <= 1'b0;
        end else if (wr_en && (reg_sel == REG_CTRL)) begin
            len    <= data_in[CTRL_LEN_LSB +: FiltBits];
            irq_en <= data_in[CTRL_IRQ_EN];
        end
    end

    // Level interrupt, one cycle behind the sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            change_irq <= 1'b0;
        end else begin
            change_irq <= irq_en & (|sticky);
        end
    end

endmodule

// File: tb/tb_gpio_in_demux.sv
// Bench for gpio_in_demux: directed scenarios plus randomized pin and bus
// traffic, compared every cycle against a behavioural model.
module tb_gpio_in_demux;

    logic        clk;
    logic        reset;
    logic [71:0] gpio_in;
    logic [71:0] io_bits_in;
    logic [15:0] addr;
    logic        read_strobe;
    logic        write_strobe;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read_valid;
    logic        change_irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_in_demux dut (
        .clk          (clk),
        .reset        (reset),
        .gpio_in      (gpio_in),
        .io_bits_in   (io_bits_in),
        .addr         (addr),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .data_in      (data_in),
        .data_out     (data_out),
        .read_valid   (read_valid),
        .change_irq   (change_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [71:0] m_pipe1, m_pipe2;      // pin values delayed one and two cycles
    logic [71:0] m_filt, m_sticky, m_shadow;
    logic [71:0] m_set, m_clr, m_nfilt;
    int          m_run [72];            // consecutive cycles of disagreement, mod 16
    int          m_prime_left;
    logic [3:0]  m_len;
    logic        m_irq_en, m_irq, m_rv, m_irq_next;
    logic [31:0] m_dout;
    bit          started = 0;

    initial begin
        m_pipe1 = '0; m_pipe2 = '0;
    end

    function automatic logic [31:0] reg_word(input logic [2:0] a);
        case (a)
            3'd0: return m_filt[31:0];
            3'd1: return m_shadow[63:32];
            3'd2: return {24'b0, m_shadow[71:64]};
            3'd3: return m_sticky[31:0];
            3'd4: return m_sticky[63:32];
            3'd5: return {24'b0, m_sticky[71:64]};
            3'd6: return {27'b0, m_irq_en, m_len};
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            started      = 1;
            m_filt       = '0;
            m_sticky     = '0;
            m_shadow     = '0;
            m_len        = '0;
            m_irq_en     = 1'b0;
            m_irq        = 1'b0;
            m_rv         = 1'b0;
            m_dout       = '0;
            m_prime_left = 3;
            for (int k = 0; k < 72; k++) m_run[k] = 0;
        end else begin
            m_set      = '0;
            m_clr      = '0;
            m_nfilt    = m_filt;
            m_irq_next = m_irq_en & (|m_sticky);
            m_rv       = read_strobe;
            if (read_strobe) begin
                m_dout = reg_word(addr[2:0]);
                if (addr[2:0] == 3'd0) m_shadow = {m_filt[71:32], 32'b0};
            end
            for (int k = 0; k < 72; k++) begin
                if (m_prime_left > 0) begin
                    m_nfilt[k] = m_pipe2[k];
                    m_run[k]   = 0;
                end else if (m_pipe2[k] == m_filt[k]) begin
                    m_run[k] = 0;
                end else if (m_run[k] == int'(m_len)) begin
                    m_nfilt[k] = m_pipe2[k];
                    m_run[k]   = 0;
                    m_set[k]   = 1'b1;
                end else begin
                    m_run[k] = (m_run[k] + 1) % 16;
                end
            end
            if (write_strobe && (m_prime_left == 0)) begin
                case (addr[2:0])
                    3'd3: m_clr[31:0]  = data_in;
                    3'd4: m_clr[63:32] = data_in;
                    3'd5: m_clr[71:64] = data_in[7:0];
                    3'd6: begin m_len = data_in[3:0]; m_irq_en = data_in[4]; end
                    default: ;
                endcase
            end
            m_sticky = (m_sticky & ~m_clr) | m_set;
            m_filt   = m_nfilt;
            m_irq    = m_irq_next;
            if (m_prime_left > 0) m_prime_left--;
        end
        m_pipe2 = m_pipe1;
        m_pipe1 = gpio_in;
    end

    // Continuous comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("io_bits_in", io_bits_in, m_filt);
            chk("change_irq", change_irq, m_irq);
            chk("read_valid", read_valid, m_rv);
            chk("data_out",   data_out,   m_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = {13'b0, a}; data_in = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        addr = {13'b0, a}; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        chk("read_valid_pulse", read_valid, 1'b1);
        d = data_out;
    endtask

    task automatic clear_sticky();
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_write(3'd5, 32'hFFFF_FFFF);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;

    initial begin
        reset = 1'b1; gpio_in = '1; addr = '0; data_in = '0;
        read_strobe = 1'b0; write_strobe = 1'b0;
        tick(4);
        chk("reset_io_bits", io_bits_in, 72'd0);
        chk("reset_irq", change_irq, 1'b0);
        chk("reset_rvalid", read_valid, 1'b0);
        chk("reset_dout", data_out, 32'd0);

        // Prime with pins idling high: no sticky flags
        reset = 1'b0;
        tick(3);
        chk("prime_all_ones", io_bits_in, {72{1'b1}});
        bus_read(3'd3, rd); chk("prime_sticky0", rd, 32'd0);
        bus_read(3'd4, rd); chk("prime_sticky1", rd, 32'd0);
        bus_read(3'd5, rd); chk("prime_sticky2", rd, 32'd0);

        // L=0 latency on bit 40
        gpio_in = '0;
        tick(6);
        clear_sticky();
        tick(1);
        gpio_in[40] = 1'b1;
        tick(2);
        chk("bit40_early", io_bits_in[40], 1'b0);
        tick(1);
        chk("bit40_lat3", io_bits_in[40], 1'b1);
        bus_read(3'd4, rd); chk("sticky1_bit40", rd, 32'h0000_0100);

        // L=5: short pulse rejected, long pulse accepted after 8 cycles
        clear_sticky();
        bus_write(3'd6, 32'd5);
        gpio_in[0] = 1'b1;
        tick(3);
        gpio_in[0] = 1'b0;
        tick(10);
        chk("glitch_io0", io_bits_in[0], 1'b0);
        bus_read(3'd3, rd); chk("glitch_sticky0", rd, 32'd0);
        gpio_in[0] = 1'b1;
        tick(7);
        chk("long_io0_early", io_bits_in[0], 1'b0);
        tick(1);
        chk("long_io0_lat8", io_bits_in[0], 1'b1);
        tick(2);
        gpio_in[0] = 1'b0;
        tick(12);

        // Interrupt on bit 70, W1C clearing, and set-beats-clear
        bus_write(3'd6, 32'h10);
        clear_sticky();
        tick(2);
        chk("irq_idle", change_irq, 1'b0);
        gpio_in[70] = 1'b1;
        tick(5);
        chk("irq_set", change_irq, 1'b1);
        bus_write(3'd5, 32'h40);
        chk("irq_hold_one", change_irq, 1'b1);
        tick(1);
        chk("irq_cleared", change_irq, 1'b0);
        gpio_in[70] = 1'b0;
        tick(2);
        bus_write(3'd5, 32'h40);
        bus_read(3'd5, rd); chk("set_beats_clear", rd, 32'h40);
        bus_write(3'd5, 32'hFFFF_FFFF);

        // Shadow snapshot of the upper filt word
        bus_read(3'd0, rd);
        gpio_in[65] = 1'b1;
        tick(5);
        chk("bit65_in", io_bits_in[65], 1'b1);
        bus_read(3'd2, rd); chk("shadow_pre_change", rd, 32'd0);
        tick(1);
        chk("rvalid_one_cycle", read_valid, 1'b0);
        bus_read(3'd0, rd);
        bus_read(3'd2, rd); chk("shadow_post_change", rd, 32'h2);

        // Reset cancels a pending read
        addr = 16'd6; read_strobe = 1'b1; reset = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        chk("reset_drops_read", read_valid, 1'b0);
        chk("reset_clears_dout", data_out, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(4);

        // Randomized pins and bus traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) gpio_in[$urandom_range(0, 71)] ^= 1'b1;
            read_strobe  = ($urandom_range(0, 3) == 0);
            write_strobe = ($urandom_range(0, 5) == 0);
            addr         = 16'($urandom);
            data_in      = $urandom;
            reset        = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        read_strobe = 1'b0; write_strobe = 1'b0; reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
